// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared icache state encodings and line geometry
package icache_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MISS = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int LINE_BYTES = 4;
   localparam int CNT_BITS   = $clog2(LINE_BYTES);
   localparam logic [CNT_BITS-1:0] LAST_BYTE = CNT_BITS'(LINE_BYTES - 1);

endpackage

// File: rtl/icache_array.sv
// rtl/icache_array.sv - direct-mapped tag/data/valid storage, comb read, sync write
module icache_array #(
   parameter int INDEX_BITS = 6,
   parameter int TAG_BITS   = 24
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic [INDEX_BITS-1:0] rd_index,
   output logic                  rd_valid,
   output logic [TAG_BITS-1:0]   rd_tag,
   output logic [31:0]           rd_data,
   input  logic                  we,
   input  logic [INDEX_BITS-1:0] wr_index,
   input  logic [TAG_BITS-1:0]   wr_tag,
   input  logic [31:0]           wr_data
);
   localparam int LINES = 1 << INDEX_BITS;

   logic [LINES-1:0]    valid_q;
   logic [TAG_BITS-1:0] tag_mem  [LINES];
   logic [31:0]         data_mem [LINES];

   assign rd_valid = valid_q[rd_index];
   assign rd_tag   = tag_mem[rd_index];
   assign rd_data  = data_mem[rd_index];

   // Only the valid bits are reset; stale tag/data are masked by them.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         valid_q <= '0;
      end else if (we) begin
         valid_q[wr_index] <= 1'b1;
      end
   end

   always_ff @(posedge clk_in) begin
      if (we) begin
         tag_mem[wr_index]  <= wr_tag;
         data_mem[wr_index] <= wr_data;
      end
   end

endmodule

// File: rtl/icache.sv
// rtl/icache.sv - read-only direct-mapped instruction cache, one word per line,
// refilled a byte at a time from the memory arbiter
module icache
   import icache_pkg::*;
#(
   parameter int INDEX_BITS = 6
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        to_icache,
   input  logic [31:0] pc_to_icache,
   output logic        have_result,
   output logic [31:0] inst_from_icache,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_valid,
   input  logic [7:0]  mem_data
);
   localparam int TAG_BITS = 30 - INDEX_BITS;

   state_t                state;
   logic [CNT_BITS-1:0]   cnt;
   logic [INDEX_BITS-1:0] miss_index;
   logic [TAG_BITS-1:0]   miss_tag;
   logic [23:0]           byte_buf;

   logic                  rd_valid;
   logic [TAG_BITS-1:0]   rd_tag;
   logic [31:0]           rd_data;
   logic                  hit;
   logic                  fill_we;
   logic [31:0]           fill_word;
   logic                  unused_pc_bits;

   assign hit       = rd_valid && (rd_tag == pc_to_icache[31:INDEX_BITS+2]);
   assign fill_word = {mem_data, byte_buf};
   assign fill_we   = rdy_in && (state == MISS) && mem_valid && (cnt == LAST_BYTE);
   assign unused_pc_bits = ^pc_to_icache[1:0];

   icache_array #(
      .INDEX_BITS (INDEX_BITS),
      .TAG_BITS   (TAG_BITS)
   ) u_array (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .rd_index (pc_to_icache[INDEX_BITS+1:2]),
      .rd_valid (rd_valid),
      .rd_tag   (rd_tag),
      .rd_data  (rd_data),
      .we       (fill_we),
      .wr_index (miss_index),
      .wr_tag   (miss_tag),
      .wr_data  (fill_word)
   );

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state            <= IDLE;
         cnt              <= '0;
         miss_index       <= '0;
         miss_tag         <= '0;
         byte_buf         <= '0;
         have_result      <= 1'b0;
         inst_from_icache <= '0;
         mem_req          <= 1'b0;
         mem_addr         <= '0;
      end else if (rdy_in) begin
         have_result <= 1'b0;
         unique case (state)
            IDLE: begin
               if (to_icache) begin
                  if (hit) begin
                     have_result      <= 1'b1;
                     inst_from_icache <= rd_data;
                  end else begin
                     miss_index <= pc_to_icache[INDEX_BITS+1:2];
                     miss_tag   <= pc_to_icache[31:INDEX_BITS+2];
                     cnt        <= '0;
                     mem_req    <= 1'b1;
                     mem_addr   <= {pc_to_icache[31:2], 2'b00};
                     state      <= MISS;
                  end
               end
            end
            MISS: begin
               if (mem_valid) begin
                  cnt      <= cnt + 1'b1;
                  mem_addr <= mem_addr + 32'd1;
                  // The last byte goes straight into the line and the result
                  // register, so the RESP cycle itself carries have_result.
                  if (cnt == LAST_BYTE) begin
                     mem_req          <= 1'b0;
                     have_result      <= 1'b1;
                     inst_from_icache <= fill_word;
                     state            <= RESP;
                  end else begin
                     byte_buf[{cnt, 3'b000} +: 8] <= mem_data;
                  end
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
